// File: rtl/conv_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pass_sequencer
//  Purpose  : Sequences one convolution layer pass over the shared DSP MAC
//             datapath: start/done handshake, read-pipeline prime, then
//             tap -> bank-group -> pixel -> pass stepping, followed by a
//             drain of the accumulator pipeline.
//  Ports    : clock, reset (async, active-high)
//             start        - layer start request (sampled in IDLE only)
//             stall        - upstream hold, freezes issue while high
//             busy         - high in every state except IDLE
//             done         - one-cycle pulse at layer completion
//             rden         - read enable to in-feature / weight M9Ks
//             enable_mult  - tap issue valid to the multiplier array
//             accum_sload  - first tap of a pixel, reloads the accumulator
//             bank_sel     - bank-group select for the in-feature mux
//             tap_idx      - tap index within the current group
//             pixel_idx    - current output pixel
//             pass_idx     - current output-map pass
//             result_valid - pulse when a pixel accumulation is complete
//  Revision : 1.0 - initial release
// ============================================================================
module conv_pass_sequencer #(
  parameter int NUM_BANK_GROUPS  = 10,
  parameter int CYCLES_PER_GROUP = 9,
  parameter int OUT_PIXELS       = 576,
  parameter int NUM_PASSES       = 2,
  parameter int RD_LATENCY       = 2,
  parameter int PIPE_LATENCY     = 4,
  localparam int GSEL_W = (NUM_BANK_GROUPS  > 1) ? $clog2(NUM_BANK_GROUPS)  : 1,
  localparam int TAP_W  = (CYCLES_PER_GROUP > 1) ? $clog2(CYCLES_PER_GROUP) : 1,
  localparam int PIX_W  = (OUT_PIXELS       > 1) ? $clog2(OUT_PIXELS)       : 1,
  localparam int PASS_W = (NUM_PASSES       > 1) ? $clog2(NUM_PASSES)       : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rden,
  output logic              enable_mult,
  output logic              accum_sload,
  output logic [GSEL_W-1:0] bank_sel,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [PIX_W-1:0]  pixel_idx,
  output logic [PASS_W-1:0] pass_idx,
  output logic              result_valid
);

  localparam int PRIME_W = (RD_LATENCY   > 1) ? $clog2(RD_LATENCY)   : 1;
  localparam int DRAIN_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [PRIME_W-1:0]      prime_cnt;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [PIPE_LATENCY-1:0] pipe_sr;
  logic                    last_issue;

  logic tap_first, bank_first, tap_last, bank_last, pix_last, pass_last;
  logic prime_last, drain_last;

  assign tap_first  = (tap_idx  == '0);
  assign bank_first = (bank_sel == '0);
  assign tap_last   = (tap_idx   == TAP_W'(CYCLES_PER_GROUP - 1));
  assign bank_last  = (bank_sel  == GSEL_W'(NUM_BANK_GROUPS - 1));
  assign pix_last   = (pixel_idx == PIX_W'(OUT_PIXELS - 1));
  assign pass_last  = (pass_idx  == PASS_W'(NUM_PASSES - 1));
  // Integer compares keep the zero-latency prime configuration well defined
  // (PRIME is unreachable then, so prime_last simply never asserts).
  assign prime_last = (int'(prime_cnt) == RD_LATENCY - 1);
  assign drain_last = (int'(drain_cnt) == PIPE_LATENCY - 1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    rden        = 1'b0;
    enable_mult = 1'b0;
    accum_sload = 1'b0;
    last_issue  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (RD_LATENCY > 0) ? S_PRIME : S_RUN;
      end
      S_PRIME: begin
        rden = ~stall;
        if (!stall && prime_last) next_state = S_RUN;
      end
      S_RUN: begin
        rden        = ~stall;
        enable_mult = ~stall;
        accum_sload = ~stall & tap_first & bank_first;
        // Final tap of the final bank group closes one pixel accumulation.
        last_issue  = ~stall & tap_last & bank_last;
        if (last_issue && pix_last && pass_last) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Loop counters: tap -> bank group -> pixel -> pass, all frozen by stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prime_cnt <= '0;
      drain_cnt <= '0;
      tap_idx   <= '0;
      bank_sel  <= '0;
      pixel_idx <= '0;
      pass_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            prime_cnt <= '0;
            drain_cnt <= '0;
            tap_idx   <= '0;
            bank_sel  <= '0;
            pixel_idx <= '0;
            pass_idx  <= '0;
          end
        end
        S_PRIME: begin
          if (!stall) prime_cnt <= prime_last ? '0 : prime_cnt + PRIME_W'(1);
        end
        S_RUN: begin
          if (!stall) begin
            tap_idx <= tap_last ? '0 : tap_idx + TAP_W'(1);
            if (tap_last) begin
              bank_sel <= bank_last ? '0 : bank_sel + GSEL_W'(1);
              if (bank_last) begin
                pixel_idx <= pix_last ? '0 : pixel_idx + PIX_W'(1);
                if (pix_last) pass_idx <= pass_last ? '0 : pass_idx + PASS_W'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_last ? '0 : drain_cnt + DRAIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result-valid delay line. Free-running so already issued pixels keep
  // draining through a stall.
  // --------------------------------------------------------------------------
  generate
    if (PIPE_LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clock or posedge reset) begin
        if (reset) pipe_sr <= '0;
        else       pipe_sr <= last_issue;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clock or posedge reset) begin
        if (reset) pipe_sr <= '0;
        else       pipe_sr <= {pipe_sr[PIPE_LATENCY-2:0], last_issue};
      end
    end
  endgenerate

  assign result_valid = pipe_sr[PIPE_LATENCY-1];

endmodule
`default_nettype wire
